// File: rtl/i2cmb_wb_sequencer.sv
// Wishbone master that walks the i2cmb core through init, START, address, data bytes and STOP.
// Latency: one access at a time, >=1 idle cycle between accesses; every command waits for irq_i then reads CMDR.
// Backpressure: each access holds until ack_i; requests only accepted in IDLE; write bytes pulled with a one-cycle wdata_ready_o.
module i2cmb_wb_sequencer #(
    parameter int BUS_ID        = 0,
    parameter int WB_ADDR_WIDTH = 2,
    parameter int WB_DATA_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_rnw_i,
    input  logic [6:0]               req_addr_i,
    input  logic [5:0]               req_len_i,
    input  logic                     wdata_valid_i,
    output logic                     wdata_ready_o,
    input  logic [7:0]               wdata_i,
    output logic                     rdata_valid_o,
    output logic [7:0]               rdata_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic                     ack_i,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     irq_i
);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

    typedef enum logic [2:0] {INIT, IDLE, START, ADDR, WDATA, RDATA, STOP, DONE} state_t;
    typedef enum logic [2:0] {ACT_NONE, ACT_WR, ACT_RD, ACT_IRQ, ACT_EVAL, ACT_WAITV, ACT_TAKE, ACT_PUSH} act_t;

    state_t     state;
    logic [2:0] step;
    logic [6:0] addr_q;
    logic       rnw_q;
    logic [5:0] count;
    logic       err_flag;
    logic [7:0] rd_byte;
    logic [7:0] wr_byte;

    act_t                     act;
    logic [WB_ADDR_WIDTH-1:0] op_adr;
    logic [7:0]               op_dat;
    logic                     err_next;

    // rd_byte holds the last CMDR status when an EVAL step runs
    assign err_next = err_flag | (|rd_byte[6:4]);

    always_comb begin
        act    = ACT_NONE;
        op_adr = ADR_CMDR;
        op_dat = 8'h00;
        case (state)
            INIT: case (step)
                3'd0:    begin act = ACT_WR; op_adr = ADR_CSR; op_dat = 8'hC0; end
                3'd1:    begin act = ACT_WR; op_adr = ADR_DPR; op_dat = 8'(BUS_ID); end
                3'd2:    begin act = ACT_WR; op_dat = 8'h06; end
                3'd3:    act = ACT_IRQ;
                3'd4:    act = ACT_RD;
                default: act = ACT_EVAL;
            endcase
            START, STOP: case (step)
                3'd0:    begin act = ACT_WR; op_dat = (state == START) ? 8'h04 : 8'h05; end
                3'd1:    act = ACT_IRQ;
                3'd2:    act = ACT_RD;
                default: act = ACT_EVAL;
            endcase
            ADDR: case (step)
                3'd0:    begin act = ACT_WR; op_adr = ADR_DPR; op_dat = {addr_q, rnw_q}; end
                3'd1:    begin act = ACT_WR; op_dat = 8'h01; end
                3'd2:    act = ACT_IRQ;
                3'd3:    act = ACT_RD;
                default: act = ACT_EVAL;
            endcase
            WDATA: case (step)
                3'd0:    act = ACT_WAITV;
                3'd1:    act = ACT_TAKE;
                3'd2:    begin act = ACT_WR; op_adr = ADR_DPR; op_dat = wr_byte; end
                3'd3:    begin act = ACT_WR; op_dat = 8'h01; end
                3'd4:    act = ACT_IRQ;
                3'd5:    act = ACT_RD;
                default: act = ACT_EVAL;
            endcase
            RDATA: case (step)
                3'd0:    begin act = ACT_WR; op_dat = (count == 6'd1) ? 8'h03 : 8'h02; end
                3'd1:    act = ACT_IRQ;
                3'd2:    act = ACT_RD;
                3'd3:    act = ACT_EVAL;
                3'd4:    begin act = ACT_RD; op_adr = ADR_DPR; end
                default: act = ACT_PUSH;
            endcase
            default: act = ACT_NONE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= INIT;
            step          <= 3'd0;
            addr_q        <= 7'd0;
            rnw_q         <= 1'b0;
            count         <= 6'd0;
            err_flag      <= 1'b0;
            rd_byte       <= 8'h00;
            wr_byte       <= 8'h00;
            req_ready_o   <= 1'b0;
            wdata_ready_o <= 1'b0;
            rdata_valid_o <= 1'b0;
            rdata_o       <= 8'h00;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            cyc_o         <= 1'b0;
            stb_o         <= 1'b0;
            we_o          <= 1'b0;
            adr_o         <= '0;
            dat_o         <= '0;
        end else begin
            wdata_ready_o <= 1'b0;
            rdata_valid_o <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            if (cyc_o) begin
                if (ack_i) begin
                    cyc_o   <= 1'b0;
                    stb_o   <= 1'b0;
                    we_o    <= 1'b0;
                    rd_byte <= dat_i[7:0];
                    step    <= step + 3'd1;
                end
            end else if (state == IDLE) begin
                if (req_valid_i && req_ready_o) begin
                    req_ready_o <= 1'b0;
                    rnw_q       <= req_rnw_i;
                    addr_q      <= req_addr_i;
                    count       <= req_len_i;
                    step        <= 3'd0;
                    err_flag    <= (req_len_i == 6'd0);
                    state       <= (req_len_i == 6'd0) ? DONE : START;
                end
            end else if (state == DONE) begin
                done_o      <= 1'b1;
                err_o       <= err_flag;
                req_ready_o <= 1'b1;
                state       <= IDLE;
            end else begin
                case (act)
                    ACT_WR, ACT_RD: begin
                        cyc_o <= 1'b1;
                        stb_o <= 1'b1;
                        we_o  <= (act == ACT_WR);
                        adr_o <= op_adr;
                        dat_o <= WB_DATA_WIDTH'(op_dat);
                    end
                    ACT_IRQ:   if (irq_i) step <= step + 3'd1;
                    ACT_WAITV: if (wdata_valid_i) begin
                        wdata_ready_o <= 1'b1;
                        step          <= step + 3'd1;
                    end
                    ACT_TAKE: begin
                        wr_byte <= wdata_i;
                        step    <= step + 3'd1;
                    end
                    ACT_PUSH: begin
                        rdata_o       <= rd_byte;
                        rdata_valid_o <= 1'b1;
                        count         <= (count != 6'd0) ? count - 6'd1 : 6'd0;
                        step          <= 3'd0;
                        if (count == 6'd1) state <= STOP;
                    end
                    ACT_EVAL: begin
                        err_flag <= err_next;
                        step     <= 3'd0;
                        case (state)
                            INIT: begin
                                state       <= IDLE;
                                req_ready_o <= 1'b1;
                            end
                            START: state <= err_next ? STOP : ADDR;
                            ADDR:  state <= err_next ? STOP : (rnw_q ? RDATA : WDATA);
                            WDATA: begin
                                count <= (count != 6'd0) ? count - 6'd1 : 6'd0;
                                if (err_next || count == 6'd1) state <= STOP;
                            end
                            // status evaluated mid-byte; the DPR read follows
                            RDATA: step  <= step + 3'd1;
                            STOP:  state <= DONE;
                            default: state <= IDLE;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
// Bench for i2cmb_wb_sequencer: Wishbone slave/irq model, directed requests, queue-based scoreboard.
`timescale 1ns/1ps
module tb_i2cmb_wb_sequencer;
    logic       clk_i, rst_ni;
    logic       req_valid_i, req_ready_o, req_rnw_i;
    logic [6:0] req_addr_i;
    logic [5:0] req_len_i;
    logic       wdata_valid_i, wdata_ready_o;
    logic [7:0] wdata_i;
    logic       rdata_valid_o;
    logic [7:0] rdata_o;
    logic       done_o, err_o, cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic       ack_i;
    logic [7:0] dat_i;
    logic       irq_i;

    i2cmb_wb_sequencer dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rnw_i(req_rnw_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
        .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o),
        .done_o(done_o), .err_o(err_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .dat_i(dat_i), .irq_i(irq_i)
    );

    typedef struct packed {
        logic [1:0] kind;
        logic       we;
        logic [1:0] adr;
        logic [7:0] dat;
    } ev_t;

    localparam logic [1:0] K_WB = 2'd0, K_RDATA = 2'd1, K_DONE = 2'd2;

    ev_t        exp_q[$];
    logic [7:0] status_q[$];
    logic [7:0] dpr_q[$];
    int         checks;
    int         failures;
    int         ack_delay;
    bit         spur_irq;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endfunction

    function automatic void check_ev(input ev_t got);
        ev_t want;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got=%h want=none", got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                failures++;
                $display("FAIL event got kind=%0d we=%0b adr=%0d dat=%h want kind=%0d we=%0b adr=%0d dat=%h",
                         got.kind, got.we, got.adr, got.dat, want.kind, want.we, want.adr, want.dat);
            end
        end
    endfunction

    function automatic void exp_wr(input logic [1:0] a, input logic [7:0] d);
        exp_q.push_back(ev_t'{kind: K_WB, we: 1'b1, adr: a, dat: d});
    endfunction
    function automatic void exp_rd(input logic [1:0] a);
        exp_q.push_back(ev_t'{kind: K_WB, we: 1'b0, adr: a, dat: 8'h00});
    endfunction
    function automatic void exp_cmd(input logic [7:0] c);
        exp_wr(2'd2, c);
        exp_rd(2'd2);
    endfunction
    function automatic void exp_rdata(input logic [7:0] d);
        exp_q.push_back(ev_t'{kind: K_RDATA, we: 1'b0, adr: 2'd0, dat: d});
    endfunction
    function automatic void exp_done(input logic e);
        exp_q.push_back(ev_t'{kind: K_DONE, we: 1'b0, adr: 2'd0, dat: {7'd0, e}});
    endfunction
    function automatic void push_init();
        exp_wr(2'd0, 8'hC0);
        exp_wr(2'd1, 8'h00);
        exp_cmd(8'h06);
    endfunction
    function automatic void push_head(input logic [6:0] a, input logic rnw);
        exp_cmd(8'h04);
        exp_wr(2'd1, {a, rnw});
        exp_cmd(8'h01);
    endfunction
    function automatic void push_write3();
        push_head(7'h69, 1'b0);
        for (int b = 0; b < 3; b++) begin
            exp_wr(2'd1, 8'(b));
            exp_cmd(8'h01);
        end
        exp_cmd(8'h05);
        exp_done(1'b0);
    endfunction

    // Wishbone slave with programmable ack delay; irq raised a few cycles after each CMDR write
    initial begin
        int   wcnt, icnt;
        logic irq_pend;
        wcnt = 0; icnt = 0; irq_pend = 1'b0;
        ack_i = 1'b0; dat_i = 8'h00; irq_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                ack_i = 1'b0; wcnt = 0; icnt = 0; irq_pend = 1'b0;
            end else if (ack_i) begin
                ack_i = 1'b0;
            end else if (cyc_o && stb_o) begin
                if (wcnt < ack_delay) wcnt++;
                else begin
                    wcnt  = 0;
                    ack_i = 1'b1;
                    dat_i = 8'h00;
                    if (we_o && adr_o == 2'd2) icnt = 3;
                    if (!we_o && adr_o == 2'd2) begin
                        irq_pend = 1'b0;
                        dat_i = (status_q.size() != 0) ? status_q.pop_front() : 8'h80;
                    end
                    if (!we_o && adr_o == 2'd1)
                        dat_i = (dpr_q.size() != 0) ? dpr_q.pop_front() : 8'hEE;
                end
            end
            if (icnt > 0) begin
                icnt--;
                if (icnt == 0) irq_pend = 1'b1;
            end
            irq_i = irq_pend | spur_irq;
        end
    end

    // Monitor: samples just after the slave updates, i.e. what the DUT sees at the next rising edge
    initial begin
        logic       pbusy, pack, pready;
        logic       hwe;
        logic [1:0] hadr;
        logic [7:0] hdat;
        ev_t        ev;
        pbusy = 1'b0; pack = 1'b0; pready = 1'b0;
        hwe = 1'b0; hadr = 2'd0; hdat = 8'h00;
        forever begin
            @(negedge clk_i);
            #1;
            if (pack) chk("wb_gap_cyc", 32'(cyc_o), 32'd0);
            if (cyc_o && stb_o) begin
                if (pbusy) chk("wb_stable", {21'd0, hwe, hadr, hdat}, {21'd0, we_o, adr_o, dat_o});
                else begin
                    hwe = we_o; hadr = adr_o; hdat = dat_o;
                end
                if (ack_i) begin
                    ev = ev_t'{kind: K_WB, we: we_o, adr: adr_o, dat: we_o ? dat_o : 8'h00};
                    check_ev(ev);
                end
            end
            if (rdata_valid_o) begin
                ev = ev_t'{kind: K_RDATA, we: 1'b0, adr: 2'd0, dat: rdata_o};
                check_ev(ev);
            end
            if (done_o) begin
                ev = ev_t'{kind: K_DONE, we: 1'b0, adr: 2'd0, dat: {7'd0, err_o}};
                check_ev(ev);
            end
            if (wdata_ready_o) chk("wdata_ready_width", 32'(pready), 32'd0);
            pbusy  = cyc_o && stb_o && !ack_i;
            pack   = cyc_o && stb_o && ack_i;
            pready = wdata_ready_o;
        end
    end

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && req_ready_o) && n < budget) begin
            @(negedge clk_i);
            #2;
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s timeout pending=%0d ready=%0b want pending=0 ready=1", name, exp_q.size(), req_ready_o);
        end
    endtask

    task automatic send_req(input logic rnw, input logic [6:0] a, input logic [5:0] len);
        @(negedge clk_i);
        req_rnw_i = rnw; req_addr_i = a; req_len_i = len; req_valid_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int stall);
        int n;
        repeat (stall) @(negedge clk_i);
        wdata_valid_i = 1'b1;
        wdata_i = d;
        n = 0;
        do begin
            @(negedge clk_i);
            #2;
            n++;
        end while (!wdata_ready_o && n < 300);
        if (!wdata_ready_o) begin
            checks++;
            failures++;
            $display("FAIL wdata_handshake timeout byte=%h got=0 want=1", d);
        end
        @(negedge clk_i);
        wdata_valid_i = 1'b0;
    endtask

    task automatic check_reset(input string name);
        chk({name, "_ctrl"}, {24'd0, cyc_o, stb_o, we_o, req_ready_o, wdata_ready_o, rdata_valid_o, done_o, err_o}, 32'd0);
        chk({name, "_data"}, {14'd0, adr_o, dat_o, rdata_o}, 32'd0);
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; ack_delay = 0; spur_irq = 1'b0;
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_rnw_i = 1'b0; req_addr_i = 7'd0; req_len_i = 6'd0;
        wdata_valid_i = 1'b0; wdata_i = 8'h00;
        repeat (3) @(negedge clk_i);
        check_reset("reset_state");

        push_init();
        rst_ni = 1'b1;
        wait_idle(200, "init");
        chk("init_ready", 32'(req_ready_o), 32'd1);

        spur_irq = 1'b1;
        repeat (5) @(negedge clk_i);
        spur_irq = 1'b0;
        repeat (3) @(negedge clk_i);
        #2;
        chk("idle_ignores_irq", {30'd0, cyc_o, req_ready_o}, 32'd1);

        push_write3();
        send_req(1'b0, 7'h69, 6'd3);
        for (int b = 0; b < 3; b++) send_byte(8'(b), 0);
        wait_idle(400, "write3");

        dpr_q.push_back(8'h64);
        dpr_q.push_back(8'h65);
        push_head(7'h22, 1'b1);
        exp_cmd(8'h02); exp_rd(2'd1); exp_rdata(8'h64);
        exp_cmd(8'h03); exp_rd(2'd1); exp_rdata(8'h65);
        exp_cmd(8'h05); exp_done(1'b0);
        send_req(1'b1, 7'h22, 6'd2);
        wait_idle(400, "read2");
        repeat (4) @(negedge clk_i);
        #2;
        chk("rdata_hold", 32'(rdata_o), 32'h65);

        status_q.push_back(8'h80);
        status_q.push_back(8'h40);
        push_head(7'h10, 1'b0);
        exp_cmd(8'h05); exp_done(1'b1);
        send_req(1'b0, 7'h10, 6'd2);
        wait_idle(400, "addr_nak");

        ack_delay = 5;
        push_write3();
        send_req(1'b0, 7'h69, 6'd3);
        for (int b = 0; b < 3; b++) send_byte(8'(b), 10);
        wait_idle(1500, "write3_stalled");
        ack_delay = 0;

        push_head(7'h69, 1'b0);
        exp_wr(2'd1, 8'h00); exp_cmd(8'h01);
        exp_wr(2'd1, 8'h01);
        send_req(1'b0, 7'h69, 6'd3);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk_i);
            #2;
            n++;
        end
        chk("pre_reset_drained", 32'(exp_q.size()), 32'd0);
        #1 rst_ni = 1'b0;
        #1 check_reset("reset_mid");
        repeat (3) @(negedge clk_i);
        check_reset("reset_hold");
        push_init();
        rst_ni = 1'b1;
        wait_idle(200, "reinit");

        exp_done(1'b1);
        send_req(1'b0, 7'h33, 6'd0);
        wait_idle(50, "len0");
        repeat (6) @(negedge clk_i);
        #2;
        chk("len0_no_bus", {30'd0, cyc_o, req_ready_o}, 32'd1);
        chk("status_q_used", 32'(status_q.size()), 32'd0);
        chk("dpr_q_used", 32'(dpr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
